// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: drives the fetch address, captures the returned word
// into a valid/ready IF/ID slot, and handles redirect, misaligned-target trap and ebreak halt.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Pc_out,
    input  logic [31:0] Instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] slot_instr;
    logic [31:0] slot_instr_next;
    logic [31:0] slot_pc;
    logic [31:0] slot_pc_next;
    logic        slot_valid;
    logic        slot_valid_next;
    logic        err;
    logic        err_next;
    logic        transfer;
    logic        slot_free;

    assign transfer  = slot_valid & if_ready;
    assign slot_free = ~slot_valid | transfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            slot_instr <= NOP_INSTR;
            slot_pc    <= 32'h0000_0000;
            slot_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            slot_instr <= slot_instr_next;
            slot_pc    <= slot_pc_next;
            slot_valid <= slot_valid_next;
            err        <= err_next;
        end
    end

    // Redirect outranks both stall and capture; the word at the old address is dropped.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        slot_instr_next = slot_instr;
        slot_pc_next    = slot_pc;
        slot_valid_next = slot_valid;
        err_next        = err;

        case (state)
            BOOT, RUN: begin
                if (redirect_valid) begin
                    slot_valid_next = 1'b0;
                    slot_instr_next = NOP_INSTR;
                    pc_next         = redirect_pc;
                    if (redirect_pc[1:0] != 2'b00) begin
                        err_next   = 1'b1;
                        state_next = HALT;
                    end else begin
                        state_next = RUN;
                    end
                end else if (state == BOOT) begin
                    state_next = RUN;
                end else if (slot_free) begin
                    slot_instr_next = Instruction;
                    slot_pc_next    = pc;
                    slot_valid_next = 1'b1;
                    if (Instruction == EBREAK_INSTR) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc + 32'd4;
                    end
                end
            end
            HALT: begin
                // Only the pending slot drains; fetch and redirect stay frozen.
                if (transfer) begin
                    slot_valid_next = 1'b0;
                    slot_instr_next = NOP_INSTR;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign Pc_out       = pc;
    assign if_valid     = slot_valid;
    assign if_instr     = slot_instr;
    assign if_pc        = slot_pc;
    assign misalign_err = err;
    assign halted       = (state == HALT);

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch stage, the requester side of Instruction_mem. Drives the fetch address `Pc_out` and consumes `Instruction`, which the memory returns combinationally in the same cycle. Registers each fetched word with its PC into an IF/ID output slot using a valid/ready handshake. Supports downstream stall, branch/jump redirect with flush, misaligned-target trap and ebreak halt.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset (must be word-aligned)
NOP_INSTR, 32'h0000_0013, value held on if_instr when the slot is empty or after reset
EBREAK_INSTR, 32'h0010_0073, encoding that halts fetch

Ports:
clk  in  1  single clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
Pc_out  out  32  fetch address to Instruction_mem
Instruction  in  32  word at Pc_out, valid in the same cycle (combinational memory read)
redirect_valid  in  1  branch/jump taken; overrides sequential fetch
redirect_pc  in  32  redirect target
if_valid  out  1  output slot holds a valid instruction
if_ready  in  1  decode accepts the slot this cycle
if_instr  out  32  fetched instruction
if_pc  out  32  address of if_instr
misalign_err  out  1  sticky flag, redirect target not word-aligned
halted  out  1  high in HALT state

Behaviour:
- Reset (rst=1 at posedge):
  - Pc_out=RESET_PC, if_valid=0, if_instr=NOP_INSTR, if_pc=0, misalign_err=0, halted=0.
  - State=BOOT.
  - Reset takes effect mid-operation from any state, including HALT.
- States:
  - BOOT: one cycle, no capture, Pc_out holds RESET_PC. Next state is RUN.
  - RUN: normal fetch.
  - HALT: no fetch. Exit only via rst.
- Handshake:
  - A transfer occurs on a posedge with if_valid=1 and if_ready=1.
  - "slot free" = if_valid=0 or a transfer this cycle.
  - if_instr and if_pc are stable while if_valid=1 and if_ready=0.
- RUN, no redirect, slot free:
  - if_instr<=Instruction, if_pc<=Pc_out, if_valid<=1.
  - Pc_out<=Pc_out+4, 32-bit wrap: 32'hFFFF_FFFC goes to 32'h0000_0000.
  - Throughput is 1 instr/cycle while if_ready=1.
  - Latency: the word at address A appears on if_instr the cycle after Pc_out=A.
- RUN, no redirect, slot not free (stall): Pc_out, if_instr, if_pc and if_valid all hold.
- RUN or BOOT, redirect_valid=1 (highest priority, beats stall and capture):
  - Slot flushed: if_valid<=0, if_instr<=NOP_INSTR. A transfer in the same cycle still counts as delivered.
  - The Instruction at the old Pc_out is discarded.
  - If redirect_pc[1:0]==0: Pc_out<=redirect_pc, state goes to RUN. First redirected instruction is valid 2 cycles after the redirect edge.
  - If redirect_pc[1:0]!=0: Pc_out<=redirect_pc, misalign_err<=1, state goes to HALT, no fetch.
- RUN capture of EBREAK_INSTR:
  - Captured and delivered normally.
  - State goes to HALT, Pc_out holds (no +4), halted<=1.
  - The slot stays valid until accepted, then if_valid<=0.
  - A redirect in the same cycle as the capture wins: no capture, no halt.
- HALT:
  - halted=1, redirect ignored, Pc_out frozen.
  - if_valid drops after the pending transfer.
  - misalign_err stays high until rst.
- BOOT with rst held: remains in reset. First capture happens on the 2nd posedge after rst deasserts.

Test Plan:
- Reset then if_ready=1, memory word[i]=i: Pc_out steps 0,4,8,... each cycle; if_valid rises 2 edges after rst drops; (if_pc, if_instr) = (0,0),(4,1),(8,2). Covers 101 words (addresses 0..400) with no gaps.
- Stall: if_ready=0 for 3 cycles while if_pc=8 → Pc_out stays 12, if_instr/if_pc stable at (8,2); on release, next delivered if_pc=12 with no skip and no duplicate.
- Redirect: redirect_valid=1, redirect_pc=32'h40 with a valid slot and if_ready=0 → next cycle if_valid=0, Pc_out=32'h40; following cycle if_pc=32'h40. Repeat with if_ready=1 in the same cycle → old slot counted delivered exactly once.
- Misaligned redirect: redirect_pc=32'h42 → misalign_err=1, halted=1, if_valid=0, Pc_out=32'h42 frozen; later redirect to 32'h0 is ignored; rst clears all flags.
- ebreak: 32'h0010_0073 at address 32'h10 → delivered with if_pc=32'h10, then halted=1, Pc_out=32'h10 frozen, no further if_valid.
- Wrap and mid-run reset: redirect to 32'hFFFF_FFFC → next Pc_out=32'h0. Assert rst for 1 cycle mid-stream → all outputs return to reset values and the fetch sequence restarts at RESET_PC.
